// File: rtl/sm3_pkg.sv
// Shared constants, types and word-level helpers for the SM3 compression engine.
// Rotations take their amount modulo 32; a zero amount returns the operand unchanged.
package sm3_pkg;

  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;
  localparam logic [255:0] IV   = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

  // Word 0 sits in the most significant 32 bits of each bus.
  function automatic logic [31:0] word256(input logic [255:0] bus, input int idx);
    return bus[255-32*idx -: 32];
  endfunction

  function automatic logic [31:0] word512(input logic [511:0] bus, input int idx);
    return bus[511-32*idx -: 32];
  endfunction

endpackage

// File: rtl/sm3_cmprss_ceil_comb.sv
// One combinational SM3 compression round: maps A..H to the next A..H.
// Tj arrives already rotated by the round index; sm_16 selects the round-0..15 boolean functions.
module sm3_cmprss_ceil_comb
  import sm3_pkg::*;
(
  input  logic [255:0] v_in,
  input  logic [31:0]  w,
  input  logic [31:0]  w_p,
  input  logic [31:0]  t_j,
  input  logic         sm_16,
  output logic [255:0] v_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] a12, ss1, ss2, ff_v, gg_v, tt1, tt2;

  assign {a, b, c, d, e, f, g, h} = v_in;

  assign a12  = rotl32(a, 5'd12);
  assign ss1  = rotl32(a12 + e + t_j, 5'd7);
  assign ss2  = ss1 ^ a12;
  assign ff_v = sm_16 ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
  assign gg_v = sm_16 ? (e ^ f ^ g) : ((e & f) | (~e & g));
  assign tt1  = ff_v + d + ss2 + w_p;
  assign tt2  = gg_v + h + ss1 + w;

  assign v_out = {tt1, a, rotl32(b, 5'd9), c, p0(tt2), e, rotl32(f, 5'd19), g};

endmodule

// File: rtl/sm3_msg_expd.sv
// Sliding 16-word message window Wj..Wj+15 with an RND_PER_CYC-wide expansion stage.
// Words produced in the same cycle feed each other directly, so wide unrolls chain combinationally.
module sm3_msg_expd
  import sm3_pkg::*;
#(
  parameter int RND_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] blk,
  output logic [31:0]  w_win [RND_PER_CYC+4]
);

  logic [31:0] win_reg  [16];
  logic [31:0] win_next [16];
  logic [31:0] ext      [16+RND_PER_CYC];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = win_reg[i];
    end
    for (int n = 16; n < 16 + RND_PER_CYC; n++) begin
      ext[n] = p1(ext[n-16] ^ ext[n-9] ^ rotl32(ext[n-3], 5'd15))
             ^ rotl32(ext[n-13], 5'd7) ^ ext[n-6];
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_win
    assign win_next[gi] = load  ? word512(blk, gi) :
                          shift ? ext[gi+RND_PER_CYC] : win_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_reg[i] <= win_next[i];
    end
  end

  for (genvar gi = 0; gi < RND_PER_CYC + 4; gi++) begin : g_out
    assign w_win[gi] = win_reg[gi];
  end

endmodule

// File: rtl/sm3_cmprss_iter.sv
// Iterative SM3 compression engine: V(i+1) = CF(V(i), B(i)), RND_PER_CYC rounds per clock.
// Accepts one block in IDLE, runs 64/RND_PER_CYC cycles, then holds the result in DONE until taken.
module sm3_cmprss_iter
  import sm3_pkg::*;
#(
  parameter int RND_PER_CYC = 1,
  parameter bit FEED_FWD    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] blk_i,
  input  logic [255:0] v_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] v_o,
  output logic         busy_o
);

  if (!(RND_PER_CYC == 1 || RND_PER_CYC == 2 || RND_PER_CYC == 4 || RND_PER_CYC == 8)) begin : g_bad_rnd
    $error("sm3_cmprss_iter: RND_PER_CYC must be 1, 2, 4 or 8");
  end

  localparam logic [6:0] RND_STEP = 7'(RND_PER_CYC);

  state_t       state_reg, state_next;
  logic [6:0]   j_reg;
  logic [255:0] abcd_reg, vi_reg, v_o_reg;
  logic [255:0] rnd_out;
  logic [31:0]  w_win [RND_PER_CYC+4];
  logic         accept, run_act, run_last;

  assign accept   = (state_reg == ST_IDLE) && in_valid;
  assign run_act  = (state_reg == ST_RUN);
  assign run_last = run_act && (j_reg + RND_STEP == 7'd64);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)                      state_next = ST_RUN;
      ST_RUN:  if (j_reg + RND_STEP == 7'd64)     state_next = ST_DONE;
      ST_DONE: if (out_ready)                     state_next = ST_IDLE;
      default:                                    state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so no input-to-output combinational path exists.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy_o    = 1'b0;
    case (state_reg)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy_o    = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign v_o = v_o_reg;

  sm3_msg_expd #(
    .RND_PER_CYC (RND_PER_CYC)
  ) u_msg_expd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (run_act),
    .blk   (blk_i),
    .w_win (w_win)
  );

  for (genvar gi = 0; gi < RND_PER_CYC; gi++) begin : g_rnd
    logic [6:0]   k;
    logic [31:0]  t_j;
    logic [255:0] v_in_w, v_out_w;

    assign k   = j_reg + 7'(gi);
    assign t_j = rotl32((k < 7'd16) ? T_LO : T_HI, k[4:0]);

    if (gi == 0) begin : g_head
      assign v_in_w = abcd_reg;
    end else begin : g_link
      assign v_in_w = g_rnd[gi-1].v_out_w;
    end

    sm3_cmprss_ceil_comb u_ceil (
      .v_in  (v_in_w),
      .w     (w_win[gi]),
      .w_p   (w_win[gi] ^ w_win[gi+4]),
      .t_j   (t_j),
      .sm_16 (k < 7'd16),
      .v_out (v_out_w)
    );
  end

  assign rnd_out = g_rnd[RND_PER_CYC-1].v_out_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_reg    <= '0;
      abcd_reg <= '0;
      vi_reg   <= '0;
      v_o_reg  <= '0;
    end else if (accept) begin
      j_reg    <= '0;
      abcd_reg <= v_i;
      vi_reg   <= v_i;
    end else if (run_act) begin
      j_reg    <= j_reg + RND_STEP;
      abcd_reg <= rnd_out;
      if (run_last) v_o_reg <= FEED_FWD ? (rnd_out ^ vi_reg) : rnd_out;
    end
  end

endmodule

// File: doc/sm3_cmprss_iter.md
Name: sm3_cmprss_iter

Overview:
- Iterative SM3 compression engine: computes V(i+1) = CF(V(i), B(i)) for one 512-bit message block.
- Parametrised unroll: RND_PER_CYC compression rounds are evaluated per clock.
- Message expansion is on-the-fly; Tj and round-mode flags are generated internally.
- Sits between the SM3 padding/block-feeder and the digest register file in the sm3 peripheral; valid/ready handshakes on both sides.

Parameters:
- RND_PER_CYC, 1, rounds per clock. Legal: 1, 2, 4, 8. Any other value is an elaboration error.
- FEED_FWD, 1, 1 = output V(i) XOR ABCDEFGH (standard CF). 0 = output raw ABCDEFGH, for debug/KAT of the round chain.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  block + chaining value present
- in_ready  out  1  engine can accept a block
- blk_i  in  512  message block; word W0 = blk_i[511:480], big-endian word order
- v_i  in  256  chaining value V(i); A = v_i[255:224] … H = v_i[31:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- v_o  out  256  V(i+1), same word packing as v_i
- busy_o  out  1  engine in RUN state

Behaviour:
- Reset: state = IDLE; in_ready = 1; out_valid = 0; busy_o = 0; v_o = 0; round counter j = 0; W window = 0; A–H = 0.
- One clock domain only; no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch blk_i into the 16-word W window, latch v_i into A–H and into a V(i) copy.
  - j <= 0; go to RUN.
- RUN:
  - in_ready = 0; busy_o = 1.
  - Each cycle applies rounds j … j+RND_PER_CYC-1 as a combinational chain.
  - Round k uses:
    - sm_16 = (k < 16)
    - Tj = ROTL(0x79cc4519, k) for k < 16, else ROTL(0x7a879d8a, k mod 32)
    - Wk, and W'k = Wk ^ Wk+4
  - j <= j + RND_PER_CYC. When j + RND_PER_CYC == 64, go to DONE.
  - RUN lasts exactly 64/RND_PER_CYC cycles.
- Message expansion:
  - The window always holds Wj … Wj+15.
  - Each RUN cycle, RND_PER_CYC new words are appended: Wn = P1(Wn-16 ^ Wn-9 ^ ROTL(Wn-3, 15)) ^ ROTL(Wn-13, 7) ^ Wn-6, with P1(x) = x ^ ROTL(x, 15) ^ ROTL(x, 23).
  - The window shifts by RND_PER_CYC words.
  - Words needed up to Wj+RND_PER_CYC+3 are all taken from the window. For RND_PER_CYC = 8, new words may depend on words generated in the same cycle; they are chained combinationally.
- Round arithmetic: all additions mod 2^32, no carry out. ROTL amounts are taken mod 32; ROTL by 0 is the identity.
- DONE:
  - out_valid = 1.
  - v_o = FEED_FWD ? (ABCDEFGH ^ V(i)) : ABCDEFGH; registered, loaded on the RUN→DONE edge.
  - v_o and out_valid are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid drops the next cycle.
  - v_o retains its value in IDLE.
- Latency: acceptance cycle → out_valid asserted is 64/RND_PER_CYC + 1 clocks.
- Throughput: one block per 64/RND_PER_CYC + 2 clocks with out_ready held at 1. No overlap of blocks; in_ready stays low through DONE.
- in_valid during RUN/DONE is ignored (not latched). blk_i/v_i are sampled only at acceptance and may change afterwards.
- Reset mid-operation (RUN or DONE): immediate abort to the reset state; no partial result is ever flagged valid.

Decomposition:
- Package sm3_pkg:
  - constants T_LO = 32'h79cc4519, T_HI = 32'h7a879d8a
  - IV constant (eight words)
  - rotl32 function, P0/P1 functions
  - word-packing helpers for the 256/512-bit buses
- Sub-module sm3_msg_expd: W window register plus RND_PER_CYC-wide generator. Outputs Wj…Wj+RND_PER_CYC+3 to the round chain.
- Round chain: generate-loop of RND_PER_CYC instances of the existing sm3_cmprss_ceil_comb cell, fed sm_16 and Tj per round index.

Test Plan:
- "abc" KAT:
  - blk_i = 0x61626380, 13 × 0x00000000, 0x00000000, 0x00000018
  - v_i = IV 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e
  - FEED_FWD = 1
  - -> v_o = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0
  - Run for RND_PER_CYC = 1, 2, 4, 8.
- Latency and handshake: out_ready = 1 -> out_valid rises exactly 65/33/17/9 clocks after acceptance for R = 1/2/4/8. in_ready = 0 from acceptance until the cycle after the out handshake.
- Backpressure: out_ready held 0 for 20 cycles in DONE -> v_o/out_valid stable; in_valid pulses meanwhile are not accepted; result unchanged once released.
- Two-block chain ("abcd"×16 message, 2 blocks; second v_i = first v_o) -> final v_o = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- Reset assertion mid-RUN (j = 32) -> outputs return to reset values asynchronously; a fresh "abc" block afterwards gives the correct KAT.
- FEED_FWD = 0 with all-zero blk_i and v_i -> v_o equals the golden-model 64-round output without XOR. Check v_o ^ 0 matches the FEED_FWD = 1 run.
